// File: rtl/bcedn_pkg.sv
// Shared definitions for the binary conv encoder/decoder: FSM states, size helpers,
// and the MSB-first index-word packing that both the encoder and the unpool stage use.
package bcedn_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_PIX,
        FETCH,
        EMIT
    } unpool_state_t;

    // clog2 with a floor of 1 so a degenerate range still gets a real bit.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int calc_k(input int d, input int n_pe);
        return d / n_pe;
    endfunction

    function automatic int calc_iaw(input int h, input int w, input int d, input int n_pe);
        return clog2_min1(h * w * calc_k(d, n_pe));
    endfunction

    // LSB of field i when n fields of width pw are packed with field 0 at the MSB end.
    function automatic int field_lsb(input int i, input int pw, input int n);
        return pw * (n - 1 - i);
    endfunction

    // Slice i of index word k carries the index of this channel.
    function automatic int idx_channel(input int i, input int k, input int k_words);
        return i * k_words + k;
    endfunction

endpackage

// File: rtl/bcedn_unpool_if.sv
// Pixel, index-SRAM and output bus of the unpool stage; slave is the unpool side.
interface bcedn_unpool_if #(
    parameter int D   = 512,
    parameter int IW  = 2,
    parameter int IAW = 19
);
    logic           start;
    logic           in_en;
    logic           in_ready;
    logic [D-1:0]   data_in;
    logic           pindex_rd;
    logic [IAW-1:0] pindex_rd_addr;
    logic [IW-1:0]  pindex_in;
    logic           out_en;
    logic [D-1:0]   data_out;
    logic           tg_next;

    modport master (
        output start, in_en, data_in, pindex_in,
        input  in_ready, pindex_rd, pindex_rd_addr, out_en, data_out, tg_next
    );

    modport slave (
        input  start, in_en, data_in, pindex_in,
        output in_ready, pindex_rd, pindex_rd_addr, out_en, data_out, tg_next
    );
endinterface

// File: rtl/unpool_row_buf.sv
// One pooled row: per column the D data bits plus a PW-bit max index per channel.
// Writes land on the clock edge; the read port is combinational.
module unpool_row_buf
    import bcedn_pkg::*;
#(
    parameter int W_OUT = 64,
    parameter int D     = 512,
    parameter int N_PE  = 1,
    parameter int PW    = 1,
    localparam int K    = calc_k(D, N_PE),
    localparam int KW   = clog2_min1(K),
    localparam int SW   = clog2_min1(W_OUT)
) (
    input  logic              clk,
    input  logic              dat_we,
    input  logic [SW-1:0]     dat_slot,
    input  logic [D-1:0]      dat_wr,
    input  logic              idx_we,
    input  logic [SW-1:0]     idx_slot,
    input  logic [KW-1:0]     idx_k,
    input  logic [PW*N_PE-1:0] idx_word,
    input  logic [SW-1:0]     rd_col,
    output logic [D-1:0]      rd_dat,
    output logic [D*PW-1:0]   rd_idx
);

    logic [D-1:0]    dat_mem [W_OUT];
    logic [D*PW-1:0] idx_mem [W_OUT];

    // Index fields are stored MSB-first by channel, same as the data bits.
    always_ff @(posedge clk) begin
        if (dat_we) begin
            dat_mem[dat_slot] <= dat_wr;
        end
        if (idx_we) begin
            for (int i = 0; i < N_PE; i++) begin
                for (int kk = 0; kk < K; kk++) begin
                    if (idx_k == KW'(kk)) begin
                        idx_mem[idx_slot][field_lsb(idx_channel(i, kk, K), PW, D) +: PW]
                            <= idx_word[field_lsb(i, PW, N_PE) +: PW];
                    end
                end
            end
        end
    end

    assign rd_dat = dat_mem[rd_col];
    assign rd_idx = idx_mem[rd_col];

endmodule

// File: rtl/bcedn_unpool.sv
// Binary max-unpool: buffers a pooled row plus its SRAM indices, then emits POOL_H*POOL_W*W_OUT pixels.
// Next pixel accepted K+2 cycles after the last; no output backpressure, pixels offered while busy are dropped.
module bcedn_unpool
    import bcedn_pkg::*;
#(
    parameter int H_OUT  = 16,
    parameter int W_OUT  = 64,
    parameter int D      = 512,
    parameter int N_PE   = 1,
    parameter int POOL_H = 2,
    parameter int POOL_W = 2
) (
    input  logic          clk,
    input  logic          rst,
    bcedn_unpool_if.slave bus
);

    localparam int K   = calc_k(D, N_PE);
    localparam int PW  = clog2_min1(POOL_H * POOL_W);
    localparam int IAW = calc_iaw(H_OUT, W_OUT, D, N_PE);
    localparam int KW  = clog2_min1(K);
    localparam int SW  = clog2_min1(W_OUT);
    localparam int RW  = clog2_min1(H_OUT);
    localparam int YW  = clog2_min1(POOL_H);
    localparam int XW  = clog2_min1(POOL_W);

    unpool_state_t  state;
    logic           in_ready_q;
    logic           rd_q;
    logic [IAW-1:0] addr_q;
    logic [IAW-1:0] addr_cnt;
    logic [KW-1:0]  rd_k;
    logic           cap_vld;
    logic [KW-1:0]  cap_k;
    logic [SW-1:0]  j;
    logic [RW-1:0]  r;
    logic [YW-1:0]  em_dy, nxt_dy, sel_dy;
    logic [SW-1:0]  em_col, nxt_col, sel_col;
    logic [XW-1:0]  em_dx, nxt_dx, sel_dx;
    logic           last_pos;
    logic [PW-1:0]  pos;
    logic           out_en_q;
    logic [D-1:0]   dout_q;
    logic           tg_q;
    logic           accept;
    logic [D-1:0]   row_dat;
    logic [D*PW-1:0] row_idx;
    logic [D-1:0]   dec;

    assign accept = (state == WAIT_PIX) && bus.in_en && in_ready_q;

    // Slot W_OUT-1 gets its last index word on the same edge column 0 is first decoded,
    // so W_OUT must be at least 2.
    unpool_row_buf #(
        .W_OUT(W_OUT),
        .D    (D),
        .N_PE (N_PE),
        .PW   (PW)
    ) u_row_buf (
        .clk     (clk),
        .dat_we  (accept),
        .dat_slot(j),
        .dat_wr  (bus.data_in),
        .idx_we  (cap_vld),
        .idx_slot(j),
        .idx_k   (cap_k),
        .idx_word(bus.pindex_in),
        .rd_col  (sel_col),
        .rd_dat  (row_dat),
        .rd_idx  (row_idx)
    );

    // Raster walk inside EMIT: dy outermost, then column, then dx.
    always_comb begin
        nxt_dy = em_dy;
        nxt_col = em_col;
        nxt_dx = em_dx;
        if (em_dx == XW'(POOL_W - 1)) begin
            nxt_dx = '0;
            if (em_col == SW'(W_OUT - 1)) begin
                nxt_col = '0;
                nxt_dy = em_dy + 1'b1;
            end else begin
                nxt_col = em_col + 1'b1;
            end
        end else begin
            nxt_dx = em_dx + 1'b1;
        end
        last_pos = (em_dy == YW'(POOL_H - 1)) && (em_col == SW'(W_OUT - 1))
                && (em_dx == XW'(POOL_W - 1));
    end

    // Outside EMIT the decoder looks at the first window position of column 0.
    always_comb begin
        sel_dy  = (state == EMIT) ? nxt_dy  : '0;
        sel_col = (state == EMIT) ? nxt_col : '0;
        sel_dx  = (state == EMIT) ? nxt_dx  : '0;
        pos = PW'(int'(sel_dy) * POOL_W + int'(sel_dx));
        dec = '0;
        for (int c = 0; c < D; c++) begin
            dec[D-1-c] = row_dat[D-1-c] & (row_idx[field_lsb(c, PW, D) +: PW] == pos);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            in_ready_q <= 1'b0;
            rd_q       <= 1'b0;
            addr_q     <= '0;
            addr_cnt   <= '0;
            rd_k       <= '0;
            cap_vld    <= 1'b0;
            cap_k      <= '0;
            j          <= '0;
            r          <= '0;
            em_dy      <= '0;
            em_col     <= '0;
            em_dx      <= '0;
            out_en_q   <= 1'b0;
            dout_q     <= '0;
            tg_q       <= 1'b0;
        end else begin
            tg_q    <= 1'b0;
            cap_vld <= rd_q;
            cap_k   <= rd_k;
            case (state)
                IDLE: begin
                    if (bus.start && !tg_q) begin
                        state      <= WAIT_PIX;
                        in_ready_q <= 1'b1;
                        addr_cnt   <= '0;
                        j          <= '0;
                        r          <= '0;
                    end
                end
                WAIT_PIX: begin
                    if (accept) begin
                        in_ready_q <= 1'b0;
                        rd_q       <= 1'b1;
                        addr_q     <= addr_cnt;
                        addr_cnt   <= addr_cnt + 1'b1;
                        rd_k       <= '0;
                        state      <= FETCH;
                    end
                end
                FETCH: begin
                    if (rd_q) begin
                        if (rd_k == KW'(K - 1)) begin
                            rd_q <= 1'b0;
                        end else begin
                            addr_q   <= addr_cnt;
                            addr_cnt <= addr_cnt + 1'b1;
                            rd_k     <= rd_k + 1'b1;
                        end
                    end
                    if (cap_vld && cap_k == KW'(K - 1)) begin
                        if (j == SW'(W_OUT - 1)) begin
                            j        <= '0;
                            state    <= EMIT;
                            out_en_q <= 1'b1;
                            dout_q   <= dec;
                            em_dy    <= '0;
                            em_col   <= '0;
                            em_dx    <= '0;
                        end else begin
                            j          <= j + 1'b1;
                            state      <= WAIT_PIX;
                            in_ready_q <= 1'b1;
                        end
                    end
                end
                EMIT: begin
                    if (last_pos) begin
                        out_en_q <= 1'b0;
                        dout_q   <= '0;
                        if (r == RW'(H_OUT - 1)) begin
                            tg_q  <= 1'b1;
                            state <= IDLE;
                        end else begin
                            r          <= r + 1'b1;
                            state      <= WAIT_PIX;
                            in_ready_q <= 1'b1;
                        end
                    end else begin
                        dout_q <= dec;
                        em_dy  <= nxt_dy;
                        em_col <= nxt_col;
                        em_dx  <= nxt_dx;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready       = in_ready_q;
    assign bus.pindex_rd      = rd_q;
    assign bus.pindex_rd_addr = addr_q;
    assign bus.out_en         = out_en_q;
    assign bus.data_out       = dout_q;
    assign bus.tg_next        = tg_q;

endmodule

// File: tb/tb_bcedn_unpool.sv
// Directed bench: 2x2 frame of 4-channel pixels with 2x2 pooling, plus a 3x1-pool instance.
module tb_bcedn_unpool;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    bcedn_unpool_if #(.D(4), .IW(4), .IAW(3)) ifa ();
    bcedn_unpool_if #(.D(4), .IW(4), .IAW(2)) ifb ();

    bcedn_unpool #(.H_OUT(2), .W_OUT(2), .D(4), .N_PE(2), .POOL_H(2), .POOL_W(2))
        dut_a (.clk(clk), .rst(rst), .bus(ifa));
    bcedn_unpool #(.H_OUT(1), .W_OUT(2), .D(4), .N_PE(2), .POOL_H(3), .POOL_W(1))
        dut_b (.clk(clk), .rst(rst), .bus(ifb));

    int n_chk = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Index SRAM models: one-cycle read latency.
    logic [3:0] mem_a [8];
    logic [3:0] mem_b [4];
    always @(posedge clk) if (ifa.pindex_rd) ifa.pindex_in <= mem_a[ifa.pindex_rd_addr];
    always @(posedge clk) if (ifb.pindex_rd) ifb.pindex_in <= mem_b[ifb.pindex_rd_addr];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [3:0] outq[$];
    logic [3:0] outq_b[$];
    int addrq[$], rdyq[$], rdcq[$], outcq[$], runq[$];
    int run = 0, zviol = 0, last_out = 0, tg_gap = 0, tg_cnt = 0, tg_cnt_b = 0;

    always @(negedge clk) begin
        if (ifa.out_en) begin
            outq.push_back(ifa.data_out);
            outcq.push_back(cyc);
            last_out = cyc;
            run++;
        end else begin
            if (ifa.data_out != 4'h0) zviol++;
            if (run != 0) begin
                runq.push_back(run);
                run = 0;
            end
        end
        if (ifa.pindex_rd) begin
            addrq.push_back(int'(ifa.pindex_rd_addr));
            rdcq.push_back(cyc);
        end
        if (ifa.in_ready) rdyq.push_back(cyc);
        if (ifa.tg_next) begin
            tg_cnt++;
            tg_gap = cyc - last_out;
        end
        if (ifb.out_en) outq_b.push_back(ifb.data_out);
        if (ifb.tg_next) tg_cnt_b++;
    end

    logic [3:0] e_t1 [16] = '{4'hF, 4'h0, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0,
                              4'hF, 4'h0, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
    logic [3:0] e_t2 [16] = '{4'h0, 4'h2, 4'h0, 4'h5, 4'h0, 4'h8, 4'h0, 4'h0,
                              4'h8, 4'h4, 4'h0, 4'h0, 4'h2, 4'h1, 4'h0, 4'h0};
    logic [3:0] e_t3 [16] = '{4'hC, 4'h0, 4'hC, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0,
                              4'hC, 4'h0, 4'hC, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
    logic [3:0] e_b [6]   = '{4'h4, 4'h0, 4'h2, 4'h0, 4'h1, 4'h0};

    task automatic clr_a();
        outq.delete(); addrq.delete(); rdyq.delete(); rdcq.delete();
        outcq.delete(); runq.delete();
        run = 0;
        zviol = 0;
    endtask

    task automatic start_a();
        @(negedge clk);
        ifa.start = 1'b1;
        @(posedge clk);
        #1 ifa.start = 1'b0;
    endtask

    task automatic send_a(input logic [3:0] v);
        int i = 0;
        @(negedge clk);
        while (!ifa.in_ready && i < 100) begin
            @(negedge clk);
            i++;
        end
        check("rdy_wait", ifa.in_ready, 1);
        ifa.in_en = 1'b1;
        ifa.data_in = v;
        @(posedge clk);
        #1 ifa.in_en = 1'b0;
    endtask

    task automatic wait_tg_a(input int bound);
        int t0 = tg_cnt;
        for (int i = 0; i < bound && tg_cnt == t0; i++) @(negedge clk);
        #1;
        check("tg_seen", tg_cnt != t0, 1);
        repeat (4) @(negedge clk);
        #1;
        check("tg_once", tg_cnt - t0, 1);
        check("tg_gap", tg_gap, 1);
    endtask

    task automatic chk_outs(input string tag, input logic [3:0] e [16]);
        check({tag, "_cnt"}, outq.size(), 16);
        for (int i = 0; i < 16; i++) if (i < outq.size()) check(tag, outq[i], e[i]);
        check({tag, "_runs"}, runq.size(), 2);
        for (int i = 0; i < 2; i++) if (i < runq.size()) check({tag, "_runlen"}, runq[i], 8);
        check({tag, "_zero_idle"}, zviol, 0);
    endtask

    task automatic chk_addrs(input string tag);
        check({tag, "_n"}, addrq.size(), 8);
        for (int i = 0; i < 8; i++) if (i < addrq.size()) check(tag, addrq[i], i);
    endtask

    task automatic frame_a(input logic [3:0] p0, p1, p2, p3);
        start_a();
        send_a(p0);
        send_a(p1);
        send_a(p2);
        send_a(p3);
        wait_tg_a(400);
    endtask

    initial begin
        ifa.start = 0; ifa.in_en = 0; ifa.data_in = 0;
        ifb.start = 0; ifb.in_en = 0; ifb.data_in = 0;
        for (int i = 0; i < 8; i++) mem_a[i] = 4'h0;
        for (int i = 0; i < 4; i++) mem_b[i] = 4'h0;
        repeat (2) @(negedge clk);
        check("rst_in_ready", ifa.in_ready, 0);
        check("rst_pindex_rd", ifa.pindex_rd, 0);
        check("rst_addr", ifa.pindex_rd_addr, 0);
        check("rst_out_en", ifa.out_en, 0);
        check("rst_data_out", ifa.data_out, 0);
        check("rst_tg_next", ifa.tg_next, 0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // All-ones pixels, all indices zero.
        clr_a();
        frame_a(4'hF, 4'hF, 4'hF, 4'hF);
        chk_addrs("t1_addr");
        chk_outs("t1_out", e_t1);
        if (rdyq.size() >= 2 && rdcq.size() >= 1 && outcq.size() >= 1) begin
            check("t1_read_lat", rdcq[0] - rdyq[0], 1);
            check("t1_emit_lat", outcq[0] - rdyq[1], 4);
        end
        check("t1_rdy_n", rdyq.size(), 4);

        // Mixed indices per channel.
        mem_a[0] = 4'hD; mem_a[1] = 4'h8; mem_a[2] = 4'h5; mem_a[3] = 4'h5;
        mem_a[4] = 4'h2; mem_a[5] = 4'h7; mem_a[6] = 4'h0; mem_a[7] = 4'h0;
        clr_a();
        frame_a(4'hA, 4'h5, 4'hF, 4'h0);
        chk_addrs("t2_addr");
        chk_outs("t2_out", e_t2);

        // in_en held high across the whole frame.
        for (int i = 0; i < 8; i++) mem_a[i] = 4'h0;
        clr_a();
        start_a();
        ifa.in_en = 1'b1;
        ifa.data_in = 4'hC;
        wait_tg_a(400);
        ifa.in_en = 1'b0;
        check("t3_rdy_n", rdyq.size(), 4);
        if (rdyq.size() >= 4) begin
            check("t3_rdy_gap0", rdyq[1] - rdyq[0], 4);
            check("t3_rdy_gap1", rdyq[3] - rdyq[2], 4);
        end
        chk_outs("t3_out", e_t3);

        // Reset while emitting.
        clr_a();
        start_a();
        send_a(4'hF);
        send_a(4'hF);
        for (int i = 0; i < 50 && !ifa.out_en; i++) @(negedge clk);
        check("t4_emit_seen", ifa.out_en, 1);
        check("t4_emit_dat", ifa.data_out, 4'hF);
        rst = 1'b0;
        #1;
        check("t4_rst_out_en", ifa.out_en, 0);
        check("t4_rst_data", ifa.data_out, 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1 clr_a();
        repeat (10) @(negedge clk);
        #1;
        check("t4_idle_rdy", rdyq.size(), 0);
        check("t4_idle_rd", addrq.size(), 0);
        check("t4_idle_out", outq.size(), 0);
        clr_a();
        frame_a(4'hF, 4'hF, 4'hF, 4'hF);
        chk_addrs("t4_addr");
        chk_outs("t4_out", e_t1);

        // start pulsed during FETCH is ignored.
        clr_a();
        start_a();
        send_a(4'hF);
        @(negedge clk);
        check("t5_in_fetch", ifa.pindex_rd, 1);
        ifa.start = 1'b1;
        @(posedge clk);
        #1 ifa.start = 1'b0;
        send_a(4'hF);
        send_a(4'hF);
        send_a(4'hF);
        wait_tg_a(400);
        chk_addrs("t5_addr");
        chk_outs("t5_out", e_t1);

        // 3x1 pooling: index 3 is out of range for channel 0.
        mem_b[0] = 4'hD; mem_b[1] = 4'h2; mem_b[2] = 4'h0; mem_b[3] = 4'h0;
        @(negedge clk);
        ifb.start = 1'b1;
        @(posedge clk);
        #1 ifb.start = 1'b0;
        for (int p = 0; p < 2; p++) begin
            int w = 0;
            @(negedge clk);
            while (!ifb.in_ready && w < 100) begin
                @(negedge clk);
                w++;
            end
            check("b_rdy_wait", ifb.in_ready, 1);
            ifb.in_en = 1'b1;
            ifb.data_in = (p == 0) ? 4'hF : 4'h0;
            @(posedge clk);
            #1 ifb.in_en = 1'b0;
        end
        for (int i = 0; i < 100 && tg_cnt_b == 0; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        #1;
        check("b_tg", tg_cnt_b, 1);
        check("b_cnt", outq_b.size(), 6);
        for (int i = 0; i < 6; i++) if (i < outq_b.size()) check("b_out", outq_b[i], e_b[i]);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/bcedn_unpool.md
# bcedn_unpool

Binary max-unpooling stage that sits directly downstream of the binary convolutional encoder. It accepts one pooled D-bit feature vector per pooled pixel and reads that pixel's per-channel pooling indices from the encoder's index SRAM. It then emits the full-resolution feature map in raster order, one D-bit pixel per cycle. Each channel's bit is placed at its recorded max position inside the POOL_H×POOL_W window, and all other positions in the window are zero.

## Interface
- H_OUT, 16: pooled rows per frame.
- W_OUT, 64: pooled columns per frame.
- D, 512: channels per pixel; equals the encoder's FD.
- N_PE, 1: indices per index-SRAM word; equals the encoder's PE count; D % N_PE == 0.
- POOL_H, 2: vertical pooling factor.
- POOL_W, 2: horizontal pooling factor.
- Derived constants: K = D/N_PE (SRAM words per pixel); PW = max(1, clog2(POOL_H*POOL_W)); IAW = clog2(H_OUT*W_OUT*K).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- start  in  1  one-cycle frame start pulse.
- in_en  in  1  pooled pixel valid.
- in_ready  out  1  pixel accepted when in_en && in_ready.
- data_in  in  D  pooled pixel; channel 0 = data_in[D-1].
- pindex_rd  out  1  index SRAM read strobe.
- pindex_rd_addr  out  IAW  index SRAM read address.
- pindex_in  in  PW*N_PE  read data, valid the cycle after pindex_rd.
- out_en  out  1  output pixel valid; no backpressure.
- data_out  out  D  unpooled pixel; channel 0 = MSB.
- tg_next  out  1  one-cycle pulse when the frame is complete.

## Operation
- FSM states: IDLE, WAIT_PIX, FETCH, EMIT.
- IDLE: start → WAIT_PIX; clear the pixel counter p, the column counter j and the row counter r.
- WAIT_PIX: in_ready=1. On acceptance, latch data_in into row-buffer slot j, then → FETCH.
- FETCH: issue K reads on consecutive cycles, with pindex_rd=1 and address p*K+k for k=0..K-1. The returned word for read k carries N_PE indices:
  - slice i, bits [PW*N_PE-1-PW*i -: PW], is the index for channel i*K+k;
  - the returned word is written into slot j's index field the cycle after the read;
  - after the last word is captured, p increments;
  - if j < W_OUT-1: j++ and → WAIT_PIX;
  - otherwise j=0 and → EMIT.
- EMIT: POOL_H*W_OUT*POOL_W consecutive cycles with out_en=1, ordered by dy (outer), then col, then dx.
  - Output pixel value: data_out[c] = buf[col].data[c] & (buf[col].idx[c] == dy*POOL_W+dx).
  - At the end of EMIT: if r == H_OUT-1, pulse tg_next and → IDLE; otherwise r++ and → WAIT_PIX.
- Index values ≥ POOL_H*POOL_W never match, so that channel's output is all zero across its window.
- start outside IDLE is ignored.
- in_en while in_ready=0 is ignored, and that data is lost.
- Reset (any state): → IDLE; all counters 0; buffer contents don't-care.

## Timing
- Reset values: in_ready=0, pindex_rd=0, pindex_rd_addr=0, out_en=0, data_out=0, tg_next=0.
- All outputs are registered.
- data_out is 0 whenever out_en=0.
- Acceptance at cycle t:
  - reads occur at t+1 … t+K;
  - the last word is captured at t+K+1;
  - in_ready=1 again at t+K+2 (the next pixel), or the first out_en is at t+K+2 (row complete).
- EMIT: out_en is high for exactly POOL_H*POOL_W*W_OUT contiguous cycles.
- tg_next is high the cycle after the frame's last out_en; the block is in IDLE in that same cycle.
- in_ready is 0 throughout FETCH and EMIT.
- A start in the same cycle as tg_next is ignored.

## Structure
- Shared package bcedn_pkg holds:
  - a clog2-with-floor-1 function for PW;
  - the state enum typedef;
  - a helper computing K and IAW from parameters.
- The index encoding (MSB-first channel slicing) is also defined in bcedn_pkg so the encoder and this block agree on it.
- One sub-module, unpool_row_buf: W_OUT entries of {D data bits, D*PW index bits}.
  - One data-write port, addressed by slot.
  - One index-word write port, addressed by slot and k, N_PE fields wide.
  - One combinational read port, addressed by col.
- The FSM, counters and output decode live in bcedn_unpool.

## Test plan
- H_OUT=2, W_OUT=2, D=4, N_PE=2, POOL 2×2, K=2.
  - Stimulus: start; pixels 4'b1111 with all-zero indices.
  - Response: read addresses 0,1 then 2,3. Each row emits 8 pixels, with 4'b1111 at (dy=0,dx=0) and 0 elsewhere. tg_next fires once, one cycle after the 16th out_en.
- Same config, pixel 4'b1010 with indices ch0=3, ch1=2, ch2=1, ch3=0 (words 6'b??; slices per encoding).
  - Response: window outputs (0,0)=0000, (0,1)=0010, (1,0)=0000, (1,1)=1000.
- Same config, in_en held high continuously.
  - Response: exactly one pixel is accepted per WAIT_PIX. in_ready pulses are spaced K+2 cycles apart. Pixels offered during FETCH or EMIT are dropped.
- rst asserted low mid-EMIT.
  - Response: out_en=0 and data_out=0 immediately; after release the block stays idle until start, and the next frame reads from address 0.
- start pulsed during FETCH.
  - Response: no effect; addresses continue sequentially; tg_next occurs exactly once.
- Index value 3 in a POOL 1×2 configuration (PW=1, so the maximum representable value is 1; use POOL 3×1 with index 3).
  - Response: that channel's output is zero in all three window positions.
